mac_row_feeder: RTL and testbench
=================================

// Module: mac_row_feeder
// PURPOSE
//  Upstream stage of the dual adder-tree vector MAC. Accepts a matrix-vector command and
//  reads A rows and the shared B vector from two chunk-wide SRAM read ports. Streams one
//  CHUNK = NUM_MACS*N element pair per cycle, zero-padding each row tail, and drives the
//  MAC's start/row_size so row accumulations run back-to-back with no bubbles.
// PARAMETERS
//  WIDTH     16  element width, bits (signed)
//  N         8   elements per adder tree
//  NUM_MACS  2   adder trees fed in parallel; CHUNK = NUM_MACS*N, must be a power of 2
//  ADDR_W    16  SRAM chunk-address width
// PORTS
//  clk           in   1              clock
//  rst           in   1              async reset, active-low
//  cmd_valid     in   1              command offered
//  cmd_ready     out  1              command accepted when cmd_valid & cmd_ready
//  cmd_base_a    in   ADDR_W         chunk address of A row 0
//  cmd_base_b    in   ADDR_W         chunk address of B vector
//  cmd_row_size  in   32             elements per row
//  cmd_num_rows  in   16             rows of A to process
//  mem_rd_en     out  1              read strobe, both ports
//  mem_addr_a    out  ADDR_W         A read address
//  mem_addr_b    out  ADDR_W         B read address
//  mem_rdata_a   in   CHUNK*WIDTH    A data, valid cycle after mem_rd_en
//  mem_rdata_b   in   CHUNK*WIDTH    B data, valid cycle after mem_rd_en
//  start         out  1              chunk valid / MAC run level
//  vector_a      out  CHUNK*WIDTH    element e at [e*WIDTH +: WIDTH]; tree m = e in m*N..m*N+N-1
//  vector_b      out  CHUNK*WIDTH    same packing as vector_a
//  row_size      out  32             latched cmd_row_size, stable while busy
//  row_last      out  1              current chunk is last of its row
//  busy          out  1              command in progress
//  feed_done     out  1              one-cycle pulse after final chunk
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 except cmd_ready=1; in-flight read data dropped.
//  - FSM IDLE->ISSUE->DRAIN->IDLE. cmd_ready=1 only in IDLE. On accept, latch all cmd fields;
//    CPR = ceil(row_size/CHUNK) via shift/mask (no divider).
//  - row_size==0 or num_rows==0: accept, no reads, feed_done pulses next cycle, back to IDLE.
//  - ISSUE: mem_rd_en=1 each cycle, CPR*num_rows cycles total. Row r chunk k:
//    addr_a = base_a + r*CPR + k (running incrementer); addr_b = base_b + k (resets per row).
//  - Latency: accept at cycle T -> first read T+1 -> first start/vectors T+2 (registered).
//  - Outputs: start=1 in every cycle holding valid data, continuous, no gaps, including across
//    row boundaries. row_last aligns with the last chunk of each row.
//  - Tail mask: last chunk of a row keeps V = row_size - (CPR-1)*CHUNK elements. Elements e>=V
//    are forced to 0 in both vectors. If row_size is a multiple of CHUNK, no masking.
//  - DRAIN: one cycle for the last read's data. Then start=0, feed_done=1 for 1 cycle, IDLE.
//  - No backpressure: the MAC consumes one chunk every cycle start=1.
//  - Address wrap past 2^ADDR_W-1 wraps modulo; no error.
//  - cmd_valid while busy is ignored and not queued. Next command earliest the cycle after feed_done.
//  - Async reset mid-command aborts at once; start drops in the reset cycle.
// TESTING
//  1. row_size=40, rows=2, base_a=0x10, base_b=0x80 -> addr_a 0x10..0x15; addr_b 0x80,81,82,80,81,82;
//     start high 6 consecutive cycles; row_last on chunks 3,6; elements 8..15 zero in chunks 3,6.
//  2. row_size=32, rows=1 -> 2 chunks unmasked; feed_done 1 cycle after 2nd chunk; cmd_ready back to 1.
//  3. row_size=5, rows=3 -> 3 chunks, each row_last=1, elements 5..15 zero, start held 3 cycles.
//  4. row_size=0 (and rows=0) -> no mem_rd_en, start never 1, feed_done pulse one cycle after accept.
//  5. cmd_valid held high throughout a 4-chunk command -> exactly one accept; 2nd accepted after feed_done.
//  6. rst low during chunk 2 of 6 -> all outputs 0 same cycle; after release, cmd_ready=1; new cmd runs clean.

Source files
------------

// File: rtl/mac_row_feeder.sv
// Row feeder for the dual adder-tree vector MAC: walks A rows and the shared B vector
// through two chunk-wide SRAM ports and streams tail-masked chunks back-to-back.
module mac_row_feeder #(
  parameter int WIDTH    = 16,
  parameter int N        = 8,
  parameter int NUM_MACS = 2,
  parameter int ADDR_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDR_W-1:0]             cmd_base_a,
  input  logic [ADDR_W-1:0]             cmd_base_b,
  input  logic [31:0]                   cmd_row_size,
  input  logic [15:0]                   cmd_num_rows,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr_a,
  output logic [ADDR_W-1:0]             mem_addr_b,
  input  logic [NUM_MACS*N*WIDTH-1:0]   mem_rdata_a,
  input  logic [NUM_MACS*N*WIDTH-1:0]   mem_rdata_b,
  output logic                          start,
  output logic [NUM_MACS*N*WIDTH-1:0]   vector_a,
  output logic [NUM_MACS*N*WIDTH-1:0]   vector_b,
  output logic [31:0]                   row_size,
  output logic                          row_last,
  output logic                          busy,
  output logic                          feed_done
);

  localparam int CHUNK = NUM_MACS*N;
  localparam int LOG2  = $clog2(CHUNK);
  localparam logic [LOG2:0] CHUNK_V = (LOG2+1)'(CHUNK);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, base_b_q, base_b_d;
  logic [31:0]       row_size_q, row_size_d, cpr_q, cpr_d, k_q, k_d;
  logic [15:0]       rows_q, rows_d;
  logic [LOG2:0]     tail_q, tail_d, keep_q, keep_d;
  logic              start_q, start_d, last_q, last_d, done_q, done_d;

  // Chunks per row and tail length straight from the shift/mask split of row_size.
  logic [31:0]   cmd_cpr;
  logic [LOG2:0] cmd_tail;
  assign cmd_cpr  = (cmd_row_size >> LOG2) + {31'd0, |cmd_row_size[LOG2-1:0]};
  assign cmd_tail = (|cmd_row_size[LOG2-1:0]) ? {1'b0, cmd_row_size[LOG2-1:0]} : CHUNK_V;

  assign cmd_ready = (state_q == S_IDLE) && !done_q;

  always_comb begin
    state_d    = state_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    base_b_d   = base_b_q;
    row_size_d = row_size_q;
    cpr_d      = cpr_q;
    k_d        = k_q;
    rows_d     = rows_q;
    tail_d     = tail_q;
    keep_d     = CHUNK_V;
    start_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          row_size_d = cmd_row_size;
          cpr_d      = cmd_cpr;
          tail_d     = cmd_tail;
          rows_d     = cmd_num_rows;
          addr_a_d   = cmd_base_a;
          addr_b_d   = cmd_base_b;
          base_b_d   = cmd_base_b;
          k_d        = 32'd0;
          if (cmd_row_size == 32'd0 || cmd_num_rows == 16'd0) done_d = 1'b1;
          else                                                state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The read issued this cycle lands next cycle, so its flags are staged alongside it.
        start_d  = 1'b1;
        addr_a_d = addr_a_q + ADDR_W'(1);
        if (k_q == cpr_q - 32'd1) begin
          last_d   = 1'b1;
          keep_d   = tail_q;
          k_d      = 32'd0;
          addr_b_d = base_b_q;
          rows_d   = rows_q - 16'd1;
          if (rows_q == 16'd1) state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 32'd1;
          addr_b_d = addr_b_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      base_b_q   <= '0;
      row_size_q <= '0;
      cpr_q      <= '0;
      k_q        <= '0;
      rows_q     <= '0;
      tail_q     <= '0;
      keep_q     <= '0;
      start_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      base_b_q   <= base_b_d;
      row_size_q <= row_size_d;
      cpr_q      <= cpr_d;
      k_q        <= k_d;
      rows_q     <= rows_d;
      tail_q     <= tail_d;
      keep_q     <= keep_d;
      start_q    <= start_d;
      last_q     <= last_d;
      done_q     <= done_d;
    end
  end

  assign mem_rd_en  = (state_q == S_ISSUE);
  assign mem_addr_a = addr_a_q;
  assign mem_addr_b = addr_b_q;
  assign start      = start_q;
  assign row_last   = last_q;
  assign row_size   = row_size_q;
  assign feed_done  = done_q;
  assign busy       = (state_q != S_IDLE) || done_q;

  // SRAM data passes straight through; gating by start_q drops stale data on reset.
  for (genvar e = 0; e < CHUNK; e++) begin : g_elem
    localparam logic [LOG2:0] EIDX = (LOG2+1)'(e);
    logic keep;
    assign keep = start_q && (EIDX < keep_q);
    assign vector_a[e*WIDTH +: WIDTH] = keep ? mem_rdata_a[e*WIDTH +: WIDTH] : '0;
    assign vector_b[e*WIDTH +: WIDTH] = keep ? mem_rdata_b[e*WIDTH +: WIDTH] : '0;
  end

endmodule

// File: tb/tb_mac_row_feeder.sv
// Directed table-driven bench for mac_row_feeder with a registered-read SRAM model.
module tb_mac_row_feeder;
  localparam int DW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [15:0]     cmd_base_a, cmd_base_b;
  logic [31:0]     cmd_row_size;
  logic [15:0]     cmd_num_rows;
  logic            mem_rd_en;
  logic [15:0]     mem_addr_a, mem_addr_b;
  logic [DW-1:0]   mem_rdata_a = '0;
  logic [DW-1:0]   mem_rdata_b = '0;
  logic            start;
  logic [DW-1:0]   vector_a, vector_b;
  logic [31:0]     row_size;
  logic            row_last, busy, feed_done;

  int total = 0;
  int bad   = 0;

  mac_row_feeder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_a(cmd_base_a), .cmd_base_b(cmd_base_b), .cmd_row_size(cmd_row_size),
    .cmd_num_rows(cmd_num_rows), .mem_rd_en(mem_rd_en), .mem_addr_a(mem_addr_a),
    .mem_addr_b(mem_addr_b), .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
    .start(start), .vector_a(vector_a), .vector_b(vector_b), .row_size(row_size),
    .row_last(row_last), .busy(busy), .feed_done(feed_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] elem(input bit isb, input logic [15:0] addr, input int e);
    logic [7:0] hi;
    hi = isb ? ~addr[7:0] : addr[7:0];
    return {hi, 8'(e + 1)};
  endfunction

  function automatic logic [DW-1:0] exp_vec(input bit isb, input logic [15:0] addr, input int keep);
    logic [DW-1:0] v;
    v = '0;
    for (int e = 0; e < 16; e++)
      if (e < keep) v[e*16 +: 16] = elem(isb, addr, e);
    return v;
  endfunction

  // SRAM model: data for the strobed address appears the next cycle.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      for (int e = 0; e < 16; e++) begin
        mem_rdata_a[e*16 +: 16] <= elem(1'b0, mem_addr_a, e);
        mem_rdata_b[e*16 +: 16] <= elem(1'b1, mem_addr_b, e);
      end
    end
  end

  task automatic chk_b(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0b want %0b", nm, act, exp); end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0h want %0h", nm, act, exp); end
  endtask

  task automatic chk_v(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got %0h want %0h", nm, act, exp); end
  endtask

  typedef struct {
    logic [31:0] rs;
    logic [15:0] rows;
    logic [15:0] ba;
    logic [15:0] bb;
    int          cpr;     // hand-computed chunks per row
    int          tail;    // hand-computed kept elements in last chunk
    int          chunks;  // hand-computed total chunks
  } vec_t;

  vec_t tbl[7];

  task automatic check_idle_reset(input string tag);
    chk_b({tag, "_ready"}, cmd_ready, 1'b1);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_start"}, start, 1'b0);
    chk_b({tag, "_rden"}, mem_rd_en, 1'b0);
    chk_b({tag, "_done"}, feed_done, 1'b0);
    chk_b({tag, "_last"}, row_last, 1'b0);
    chk_v({tag, "_va"}, vector_a, '0);
    chk_v({tag, "_vb"}, vector_b, '0);
    chk_w({tag, "_addra"}, 32'(mem_addr_a), 32'd0);
    chk_w({tag, "_addrb"}, 32'(mem_addr_b), 32'd0);
    chk_w({tag, "_rowsize"}, row_size, 32'd0);
  endtask

  // Cycle c counts negedges after the accepting posedge.
  task automatic run_cmd(input vec_t v);
    int fd;
    int j, k, keep;
    logic [15:0] ea, eb;
    fd = (v.chunks == 0) ? 1 : v.chunks + 2;
    @(negedge clk);
    chk_b("pre_ready", cmd_ready, 1'b1);
    cmd_row_size = v.rs; cmd_num_rows = v.rows; cmd_base_a = v.ba; cmd_base_b = v.bb;
    cmd_valid = 1'b1;
    for (int c = 1; c <= fd + 1; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk_b($sformatf("rden_c%0d", c), mem_rd_en, (c >= 1 && c <= v.chunks));
      if (c >= 1 && c <= v.chunks) begin
        j  = c - 1;
        ea = v.ba + 16'(j);
        eb = v.bb + 16'(j % v.cpr);
        chk_w($sformatf("addra_c%0d", c), 32'(mem_addr_a), 32'(ea));
        chk_w($sformatf("addrb_c%0d", c), 32'(mem_addr_b), 32'(eb));
      end
      chk_b($sformatf("start_c%0d", c), start, (c >= 2 && c <= v.chunks + 1));
      if (c >= 2 && c <= v.chunks + 1) begin
        j    = c - 2;
        k    = j % v.cpr;
        keep = (k == v.cpr - 1) ? v.tail : 16;
        ea   = v.ba + 16'(j);
        eb   = v.bb + 16'(k);
        chk_b($sformatf("last_c%0d", c), row_last, (k == v.cpr - 1));
        chk_v($sformatf("va_c%0d", c), vector_a, exp_vec(1'b0, ea, keep));
        chk_v($sformatf("vb_c%0d", c), vector_b, exp_vec(1'b1, eb, keep));
        chk_w($sformatf("rowsize_c%0d", c), row_size, v.rs);
      end else begin
        chk_b($sformatf("last0_c%0d", c), row_last, 1'b0);
        chk_v($sformatf("va0_c%0d", c), vector_a, '0);
      end
      chk_b($sformatf("done_c%0d", c), feed_done, (c == fd));
      chk_b($sformatf("ready_c%0d", c), cmd_ready, (c > fd));
      chk_b($sformatf("busy_c%0d", c), busy, (c <= fd));
    end
  endtask

  initial begin
    int n_acc, acc2;
    tbl[0] = '{rs: 40, rows: 2, ba: 16'h0010, bb: 16'h0080, cpr: 3, tail: 8,  chunks: 6};
    tbl[1] = '{rs: 32, rows: 1, ba: 16'h0020, bb: 16'h0090, cpr: 2, tail: 16, chunks: 2};
    tbl[2] = '{rs: 5,  rows: 3, ba: 16'h0030, bb: 16'h00A0, cpr: 1, tail: 5,  chunks: 3};
    tbl[3] = '{rs: 0,  rows: 4, ba: 16'h0040, bb: 16'h00B0, cpr: 1, tail: 16, chunks: 0};
    tbl[4] = '{rs: 7,  rows: 0, ba: 16'h0050, bb: 16'h00C0, cpr: 1, tail: 7,  chunks: 0};
    tbl[5] = '{rs: 17, rows: 1, ba: 16'hFFFE, bb: 16'h0010, cpr: 2, tail: 1,  chunks: 2};
    tbl[6] = '{rs: 33, rows: 2, ba: 16'hFFFC, bb: 16'hFFFF, cpr: 3, tail: 1,  chunks: 6};

    rst = 1'b0; cmd_valid = 1'b0;
    cmd_base_a = '0; cmd_base_b = '0; cmd_row_size = '0; cmd_num_rows = '0;
    repeat (3) @(negedge clk);
    check_idle_reset("rst");
    rst = 1'b1;

    foreach (tbl[i]) run_cmd(tbl[i]);

    // cmd_valid held across a 4-chunk command: exactly one accept, next after feed_done.
    @(negedge clk);
    cmd_row_size = 64; cmd_num_rows = 1; cmd_base_a = 16'h0100; cmd_base_b = 16'h0200;
    cmd_valid = 1'b1;
    n_acc = (cmd_ready) ? 1 : 0;
    acc2  = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 6)  chk_b("hold_done1", feed_done, 1'b1);
      if (c == 13) chk_b("hold_done2", feed_done, 1'b1);
      if (cmd_valid && cmd_ready) begin n_acc++; acc2 = c; end
      if (c == 8) cmd_valid = 1'b0;
    end
    chk_w("hold_accepts", 32'(n_acc), 32'd2);
    chk_w("hold_acc2_cycle", 32'(acc2), 32'd7);

    // Reset during chunk 2 of 6.
    @(negedge clk);
    cmd_row_size = 40; cmd_num_rows = 2; cmd_base_a = 16'h0300; cmd_base_b = 16'h0400;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_b("abort_pre_start", start, 1'b1);
    @(negedge clk);
    chk_b("abort_chunk2", start, 1'b1);
    rst = 1'b0;
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_b("post_rst_ready", cmd_ready, 1'b1);
    chk_b("post_rst_start", start, 1'b0);
    run_cmd(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
